mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store interface stage sitting directly downstream of the ARM datapath: consumes the datapath's computed address (ALUResult) and store data (WriteData), runs a valid/ready transaction on a data-memory bus and returns ReadData to the result mux. The bus may insert wait states, so the block raises Stall to freeze the PC register and register-file write until the access completes. Misaligned word accesses are trapped instead of issued.

## Interface
Parameters:
- none; all widths are fixed at 32-bit data/address, 4-bit strobe.

Ports:
- clk  in  1  processor clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registered outputs
- MemReq  in  1  current instruction is LDR/STR (from control unit)
- MemWrite  in  1  1 = store, 0 = load; sampled with MemReq
- ByteAccess  in  1  1 = LDRB/STRB; ignored unless DATAPATH_BYTE_MEM_EN
- Addr  in  32  byte address (datapath ALUResult)
- WriteData  in  32  store data (datapath WriteData)
- ReadData  out  32  load result to datapath result mux; registered
- Stall  out  1  hold PC and suppress RegWrite this cycle
- Fault  out  1  misaligned-access trap, combinational
- BusValid  out  1  transaction request; registered
- BusWrite  out  1  transaction is a write
- BusAddr  out  32  word-aligned address (Addr[31:2], 2'b00)
- BusWData  out  32  write data
- BusWStrb  out  4  byte-lane write strobes, bit i = bits [8i+7:8i]
- BusReady  in  1  memory accepts/completes transaction
- BusRData  in  32  read data, valid when BusValid & BusReady

## Operation
- States: IDLE, REQ, DONE.
- Misaligned: ~ByteAccess_eff & (Addr[1:0] != 0). ByteAccess_eff = ByteAccess when macro defined, else 0.
- IDLE: MemReq & ~misaligned -> latch Addr, WriteData, MemWrite, ByteAccess_eff, Addr[1:0]; set BusValid; go REQ. MemReq & misaligned -> Fault=1, no bus transaction, stay IDLE, ReadData unchanged. ~MemReq -> stay IDLE.
- REQ: BusValid=1; BusAddr/BusWData/BusWStrb/BusWrite held stable from latched values until BusReady. On BusValid & BusReady: load captures lane-selected BusRData into ReadData; store leaves ReadData unchanged; clear BusValid; go DONE. BusReady while not REQ is ignored.
- DONE: Stall=0, core commits the instruction on this edge; MemReq ignored (same instruction); go IDLE.
- Stall = (IDLE & MemReq & ~misaligned) | REQ. Fault = IDLE & MemReq & misaligned. Both 0 while reset asserted.
- Word access: BusWStrb=4'b1111, ReadData=BusRData.
- Byte access: little-endian lane k=Addr[1:0]; store drives WriteData[7:0] replicated on all four lanes, BusWStrb one-hot at bit k; load ReadData = {24'b0, BusRData[8k+7:8k]}.
- Loads drive BusWStrb=4'b0000.

## Timing
- Reset values: state IDLE, ReadData 0, BusValid 0, BusWrite 0, BusAddr 0, BusWData 0, BusWStrb 0.
- Reset mid-transaction: BusValid drops immediately (async), latched request discarded, no ReadData update.
- Zero-wait memory (BusReady high in first REQ cycle): cycle 0 IDLE Stall=1, cycle 1 REQ Stall=1, cycle 2 DONE Stall=0; ReadData valid from cycle 2.
- N wait states: REQ lasts N+1 cycles; total instruction length N+3 cycles.
- Non-memory instructions: no stall, single cycle.
- Fault costs zero cycles; exception handling is outside this block.

## Configuration
- DATAPATH_BYTE_MEM_EN defined: LDRB/STRB supported as above; byte accesses at any Addr[1:0] are aligned.
- Undefined: ByteAccess ignored, every access is word, BusWStrb=4'b1111 for stores, non-zero Addr[1:0] always faults.

## Test plan
- Word load, Addr=0x100, BusReady high in first REQ, BusRData=0xDEADBEEF -> Stall 1,1,0; BusAddr=0x100; ReadData=0xDEADBEEF in DONE.
- Word store, Addr=0x204, WriteData=0x12345678, BusReady low 3 cycles -> BusValid held 4 cycles with stable BusAddr=0x204, BusWStrb=4'b1111, BusWrite=1; Stall high 5 cycles.
- Misaligned word load Addr=0x102 -> Fault=1, Stall=0, BusValid stays 0, ReadData unchanged.
- Macro on: STRB Addr=0x303, WriteData=0xAB -> BusAddr=0x300, BusWStrb=4'b1000, BusWData=0xABABABAB; LDRB Addr=0x301, BusRData=0x11223344 -> ReadData=0x00000033.
- Reset asserted while REQ with BusReady low -> BusValid 0 same cycle, state IDLE, ReadData 0; next MemReq starts a fresh transaction.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store bus stage with wait-state stall and misaligned-access trap.
// Define DATAPATH_BYTE_MEM_EN to enable LDRB/STRB byte-lane accesses.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic        ByteAccess,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Fault,
    output logic        BusValid,
    output logic        BusWrite,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusWStrb,
    input  logic        BusReady,
    input  logic [31:0] BusRData
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state_q, state_d;
    logic        byte_eff, misaligned, accept;
    logic        byte_q, byte_d, valid_d, write_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] rdata_d, addr_d, wdata_d;
    logic [3:0]  strb_d;
    logic [7:0]  rbyte;
`ifdef DATAPATH_BYTE_MEM_EN
    assign byte_eff = ByteAccess;
`else
    assign byte_eff = ByteAccess & 1'b0;
`endif
    assign misaligned = ~byte_eff && (Addr[1:0] != 2'b00);
    assign accept     = (state_q == IDLE) && MemReq && !misaligned;
    assign Stall      = !reset && (accept || state_q == REQ);
    assign Fault      = !reset && (state_q == IDLE) && MemReq && misaligned;
    assign rbyte      = BusRData[{lane_q, 3'b000} +: 8];
    always_comb begin
        state_d = state_q;
        rdata_d = ReadData;
        valid_d = BusValid;
        write_d = BusWrite;
        addr_d  = BusAddr;
        wdata_d = BusWData;
        strb_d  = BusWStrb;
        byte_d  = byte_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = REQ;
                valid_d = 1'b1;
                write_d = MemWrite;
                addr_d  = {Addr[31:2], 2'b00};
                wdata_d = byte_eff ? {4{WriteData[7:0]}} : WriteData;
                strb_d  = !MemWrite ? 4'b0000 : byte_eff ? (4'b0001 << Addr[1:0]) : 4'b1111;
                byte_d  = byte_eff;
                lane_d  = Addr[1:0];
            end
            REQ: if (BusReady) begin
                state_d = DONE;
                valid_d = 1'b0;
                rdata_d = BusWrite ? ReadData : byte_q ? {24'b0, rbyte} : BusRData;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ReadData <= '0;
            BusValid <= 1'b0;
            BusWrite <= 1'b0;
            BusAddr  <= '0;
            BusWData <= '0;
            BusWStrb <= '0;
            byte_q   <= 1'b0;
            lane_q   <= '0;
        end else begin
            state_q  <= state_d;
            ReadData <= rdata_d;
            BusValid <= valid_d;
            BusWrite <= write_d;
            BusAddr  <= addr_d;
            BusWData <= wdata_d;
            BusWStrb <= strb_d;
            byte_q   <= byte_d;
            lane_q   <= lane_d;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench; stimulus queues expected bus beats/faults, a negedge monitor checks them.
module tb_mem_access_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        MemReq = 1'b0, MemWrite = 1'b0, ByteAccess = 1'b0, BusReady = 1'b0;
    logic [31:0] Addr = '0, WriteData = '0, BusRData = '0;
    logic [31:0] ReadData, BusAddr, BusWData;
    logic        Stall, Fault, BusValid, BusWrite;
    logic [3:0]  BusWStrb;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite), .ByteAccess(ByteAccess),
        .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall), .Fault(Fault),
        .BusValid(BusValid), .BusWrite(BusWrite), .BusAddr(BusAddr), .BusWData(BusWData),
        .BusWStrb(BusWStrb), .BusReady(BusReady), .BusRData(BusRData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_fault;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, failures = 0;
    logic [31:0] rd_model = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per bus handshake or fault, checks ReadData in the following DONE cycle.
    logic        chk_rd = 1'b0;
    logic [31:0] rd_exp = '0;
    always @(negedge clk) begin
        exp_t e;
        if (chk_rd) begin
            chk("done_readdata", ReadData, rd_exp);
            chk("done_stall", {31'b0, Stall}, 32'd0);
            chk_rd = 1'b0;
        end
        if (!reset && BusValid && BusReady) begin
            if (exp_q.size() == 0) chk("unexpected_bus_beat", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("beat_kind", {31'b0, e.is_fault}, 32'd0);
                chk("bus_write", {31'b0, BusWrite}, {31'b0, e.wr});
                chk("bus_addr", BusAddr, e.addr);
                chk("bus_wdata", BusWData, e.wdata);
                chk("bus_wstrb", {28'b0, BusWStrb}, {28'b0, e.strb});
                rd_exp = e.rdata;
                chk_rd = 1'b1;
            end
        end
        if (!reset && Fault) begin
            if (exp_q.size() == 0) chk("unexpected_fault", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("fault_kind", {31'b0, e.is_fault}, 32'd1);
                chk("fault_stall", {31'b0, Stall}, 32'd0);
                chk("fault_busvalid", {31'b0, BusValid}, 32'd0);
                chk("fault_readdata", ReadData, e.rdata);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_op(input logic wr, input logic bt, input logic [31:0] a, input logic [31:0] wd,
                          input int waits, input logic [31:0] bus_rd, input logic [31:0] exp_wd,
                          input logic [3:0] exp_strb, input logic [31:0] exp_rd);
        exp_q.push_back('{1'b0, wr, {a[31:2], 2'b00}, exp_wd, exp_strb, exp_rd});
        rd_model = exp_rd;
        MemReq = 1'b1; MemWrite = wr; ByteAccess = bt; Addr = a; WriteData = wd;
        BusReady = 1'b0; BusRData = bus_rd;
        #1;
        chk("idle_stall", {31'b0, Stall}, 32'd1);
        chk("idle_busvalid", {31'b0, BusValid}, 32'd0);
        for (int i = 0; i <= waits; i++) begin
            cyc();
            BusReady = (i == waits);
            #1;
            chk("req_stall", {31'b0, Stall}, 32'd1);
            chk("req_busvalid", {31'b0, BusValid}, 32'd1);
            chk("req_addr_stable", BusAddr, {a[31:2], 2'b00});
            chk("req_strb_stable", {28'b0, BusWStrb}, {28'b0, exp_strb});
        end
        cyc();
        BusReady = 1'b0;
        #1;
        chk("done_busvalid", {31'b0, BusValid}, 32'd0);
        cyc();
        MemReq = 1'b0;
        #1;
        chk("post_stall", {31'b0, Stall}, 32'd0);
        chk("post_busvalid", {31'b0, BusValid}, 32'd0);
    endtask

    task automatic fault_op(input logic wr, input logic bt, input logic [31:0] a);
        exp_q.push_back('{1'b1, wr, '0, '0, '0, rd_model});
        MemReq = 1'b1; MemWrite = wr; ByteAccess = bt; Addr = a; WriteData = 32'hFFFF_FFFF;
        BusReady = 1'b1;
        #1;
        chk("fault_out", {31'b0, Fault}, 32'd1);
        cyc();
        MemReq = 1'b0; BusReady = 1'b0;
        #1;
        chk("after_fault", {30'b0, Fault, BusValid}, 32'd0);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) cyc();
        chk("rst_readdata", ReadData, 32'd0);
        chk("rst_busaddr", BusAddr, 32'd0);
        chk("rst_buswdata", BusWData, 32'd0);
        chk("rst_flags", {28'b0, BusValid, BusWrite, Stall, Fault}, 32'd0);
        chk("rst_strb", {28'b0, BusWStrb}, 32'd0);
        reset = 1'b0;
        cyc();
        #1;
        chk("nonmem_stall", {31'b0, Stall}, 32'd0);
        cyc();
        mem_op(1'b0, 1'b0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 32'h0, 4'b0000, 32'hDEAD_BEEF);
        mem_op(1'b1, 1'b0, 32'h0000_0204, 32'h1234_5678, 3, 32'h5555_5555, 32'h1234_5678, 4'b1111, 32'hDEAD_BEEF);
        fault_op(1'b0, 1'b0, 32'h0000_0102);
        fault_op(1'b1, 1'b0, 32'h0000_0207);
`ifdef DATAPATH_BYTE_MEM_EN
        mem_op(1'b1, 1'b1, 32'h0000_0303, 32'hFFFF_FFAB, 1, 32'h0, 32'hABAB_ABAB, 4'b1000, 32'hDEAD_BEEF);
        mem_op(1'b0, 1'b1, 32'h0000_0301, 32'h0, 2, 32'h1122_3344, 32'h0, 4'b0000, 32'h0000_0033);
        mem_op(1'b0, 1'b1, 32'h0000_0302, 32'h0, 0, 32'h1122_3344, 32'h0, 4'b0000, 32'h0000_0022);
`else
        fault_op(1'b1, 1'b1, 32'h0000_0303);
        mem_op(1'b0, 1'b1, 32'h0000_0300, 32'h0, 1, 32'h1122_3344, 32'h0, 4'b0000, 32'h1122_3344);
        mem_op(1'b1, 1'b1, 32'h0000_0308, 32'hCAFE_0011, 0, 32'h0, 32'hCAFE_0011, 4'b1111, 32'h1122_3344);
`endif
        // Reset mid-transaction: nothing is queued, so any bus beat would be flagged by the monitor.
        MemReq = 1'b1; MemWrite = 1'b0; ByteAccess = 1'b0; Addr = 32'h0000_0400; BusReady = 1'b0;
        cyc();
        cyc();
        #3;
        chk("req_before_reset", {31'b0, BusValid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_busvalid", {31'b0, BusValid}, 32'd0);
        chk("rst_async_stall", {31'b0, Stall}, 32'd0);
        chk("rst_async_readdata", ReadData, 32'd0);
        chk("rst_async_busaddr", BusAddr, 32'd0);
        rd_model = '0;
        cyc();
        MemReq = 1'b0; reset = 1'b0;
        cyc();
        chk("rst_idle", {30'b0, Stall, BusValid}, 32'd0);
        mem_op(1'b0, 1'b0, 32'h0000_0500, 32'h0, 0, 32'hCAFE_F00D, 32'h0, 4'b0000, 32'hCAFE_F00D);
        repeat (3) cyc();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
